// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle RISC-V datapath.
// Sequences loads, stores and OP-IMM; any other opcode halts the core.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             adr_src,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       result_src,
  output logic             halted,
  output logic             retired,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECI  = 4'd6,
    S_ALUWB  = 4'd7,
    S_HALT   = 4'd8
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    halted     = 1'b0;
    retired    = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        if (opcode == OP_LOAD || opcode == OP_STORE)
          w_next = S_MEMADR;
        else if (opcode == OP_IMM)
          w_next = S_EXECI;
        else
          w_next = S_HALT;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        w_next    = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        adr_src  = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        retired    = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWR: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          retired = 1'b1;
          w_next  = S_FETCH;
        end
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retired   = 1'b1;
        w_next    = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
    // state is already FETCH under reset; only the Mealy strobes need masking
    if (rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      retired   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_cnt <= '0;
    else if (retired) r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign retire_cnt = r_cnt;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multi-cycle RISC-V datapath, sitting directly upstream of the ALU control decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives the datapath enables and mux selects and the 2-bit `alu_op` consumed by the ALU control decoder. Supported instructions are loads, stores and OP-IMM (ADDI/ANDI/ORI/SLTI); any other opcode halts the core. Memory accesses use a ready handshake, so each memory state can stretch over any number of wait cycles.

## Interface
Parameters:
- `CNT_W`, 32, width of the retired-instruction counter.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `opcode`  in  7  instruction register bits [6:0]; valid from DECODE onward.
- `mem_ready`  in  1  memory completes the current read or write this cycle.
- `pc_write`  out  1  PC register load enable.
- `ir_write`  out  1  instruction register load enable.
- `adr_src`  out  1  memory address select: 0 = PC, 1 = ALU output register.
- `mem_read`  out  1  memory read request.
- `mem_write`  out  1  memory write request.
- `reg_write`  out  1  register file write enable.
- `alu_src_a`  out  2  ALU A select: 00 = PC, 01 = old PC, 10 = rs1 register.
- `alu_src_b`  out  2  ALU B select: 00 = rs2 register, 01 = immediate, 10 = constant 4.
- `alu_op`  out  2  00 = add (address/PC), 10 = funct3-decoded, 01/11 unused.
- `result_src`  out  2  writeback select: 00 = ALU output register, 01 = memory data register, 10 = live ALU result.
- `halted`  out  1  sticky flag, set after an illegal opcode.
- `retired`  out  1  one-cycle pulse when an instruction completes.
- `retire_cnt`  out  CNT_W  count of retired instructions.

## Operation
State encoding is 4 bits. Outputs are decoded from the state. Any output not listed for a state is 0.
- FETCH: `mem_read`=1, `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, `alu_op`=00, `result_src`=10.
  - `ir_write` and `pc_write` equal `mem_ready` (Mealy gating).
  - Stay in FETCH while `mem_ready`=0; go to DECODE when it is 1.
- DECODE: `alu_src_a`=01, `alu_src_b`=01, `alu_op`=00 (precomputes branch target, currently unused). Next state by opcode:
  - 0000011 or 0100011: MEMADR.
  - 0010011: EXECI.
  - anything else: HALT.
- MEMADR: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=00. Next is MEMRD if `opcode`=0000011, otherwise MEMWR.
- MEMRD: `adr_src`=1, `mem_read`=1. Stay while `mem_ready`=0; then go to MEMWB.
- MEMWB: `result_src`=01, `reg_write`=1, `retired`=1. Then FETCH.
- MEMWR: `adr_src`=1, `mem_write`=1.
  - Stay while `mem_ready`=0.
  - On the `mem_ready`=1 cycle, `retired`=1 and next state is FETCH.
- EXECI: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=10. Then ALUWB.
- ALUWB: `result_src`=00, `reg_write`=1, `retired`=1. Then FETCH.
- HALT: all enables 0, `halted`=1. Exited only by `rst`.

Retired-instruction counter:
- `retire_cnt` increments by 1 on every clock edge where `retired`=1.
- It wraps modulo 2^CNT_W with no saturation.

Reset:
- Asserting `rst` asynchronously forces state to FETCH, `retire_cnt` to 0 and `halted` to 0.
- While `rst`=1, all enables/requests (`pc_write`, `ir_write`, `mem_read`, `mem_write`, `reg_write`, `retired`) are forced to 0 regardless of `mem_ready`.
- While `rst`=1, selects hold their FETCH values: `alu_src_b`=10, `result_src`=10, others 0.
- Reset mid-instruction abandons the instruction with no write and no retire. The first cycle after release is FETCH.

## Timing
- Minimum cycles per instruction with `mem_ready` tied to 1: load 5, store 4, OP-IMM 4.
- Each `mem_ready`=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- `mem_read`/`mem_write` stay high and `adr_src` stays stable for the whole wait period.
- `retired` is asserted in the final cycle of the instruction; `retire_cnt` shows the new value one cycle later.
- An illegal opcode reaches HALT one cycle after DECODE. `halted` rises on that edge and is never followed by `retired`.
- `mem_ready` is ignored outside FETCH, MEMRD and MEMWR.

## Test plan
- Reset, then `mem_ready`=1 with an ADDI opcode (0010011): states FETCH→DECODE→EXECI→ALUWB.
  - `alu_op`=10 in EXECI; `reg_write`=1 only in ALUWB.
  - `retire_cnt`=1 after 4 cycles.
- Load with `mem_ready` low for 2 cycles in FETCH and 3 cycles in MEMRD: total 10 cycles.
  - `ir_write` and `pc_write` pulse exactly once.
  - `adr_src`=1 throughout MEMRD; `result_src`=01 in MEMWB.
- Store (0100011) with `mem_ready`=1: `mem_write` high for exactly 1 cycle, `reg_write` never high, `retired` in the MEMWR cycle, 4 cycles total.
- Opcode 1100011 in DECODE: HALT on the next edge, `halted`=1, `retire_cnt` unchanged. The state stays in HALT for 20 cycles with all enables 0.
- Assert `rst` asynchronously mid-MEMRD with `mem_ready`=1:
  - All strobes drop immediately and no `reg_write` occurs.
  - After release, FETCH with `retire_cnt`=0 and `halted`=0.
- With CNT_W=4, retire 17 OP-IMM instructions back to back: `retire_cnt` wraps 15→0 and ends at 1.
